// File: rtl/bias_loader_pkg.sv
// Shared constants for the bias loader and the bias select mux it feeds.
// The bias index encoding here doubles as the mux's 2-bit select encoding.
package bias_loader_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int BIAS_SLOTS         = 4;

    localparam logic [1:0] IDX_HID    = 2'd0;
    localparam logic [1:0] IDX_HID_10 = 2'd1;
    localparam logic [1:0] IDX_HID_20 = 2'd2;
    localparam logic [1:0] IDX_OUT    = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } loaderState_t;

endpackage

// File: rtl/bias_shadow_bank.sv
// Staging registers for an in-flight bias set: indexed single-word writes,
// synchronous clear, and all words readable in parallel for an atomic commit.
module bias_shadow_bank
    import bias_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_BIAS   = BIAS_SLOTS
) (
    input  logic                                 clk,
    input  logic                                 clear_i,
    input  logic                                 wrEn_i,
    input  logic [1:0]                           wrIdx_i,
    input  logic [DATA_WIDTH-1:0]                wrData_i,
    output logic [NUM_BIAS-1:0][DATA_WIDTH-1:0]  rdData_o
);

    logic [NUM_BIAS-1:0][DATA_WIDTH-1:0] bank_q;

    always_ff @(posedge clk) begin
        if (clear_i) begin
            bank_q <= '0;
        end else if (wrEn_i) begin
            bank_q[wrIdx_i] <= wrData_i;
        end
    end

    assign rdData_o = bank_q;

endmodule

// File: rtl/bias_loader.sv
// Collects four bias words over valid/ready into a shadow bank and commits
// them to the bias outputs in one edge so the mux never sees a partial set.
module bias_loader
    import bias_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_BIAS   = BIAS_SLOTS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [1:0]            wr_idx_o,
    output logic [DATA_WIDTH-1:0] bias_hid_o,
    output logic [DATA_WIDTH-1:0] bias_hid_10_o,
    output logic [DATA_WIDTH-1:0] bias_hid_20_o,
    output logic [DATA_WIDTH-1:0] bias_out_o,
    output logic                  loaded_o,
    output logic                  busy_o
);

    loaderState_t state_q, state_d;
    logic [1:0]   wrIdx_q, wrIdx_d;
    logic         loaded_q, loaded_d;
    logic         busy_q, busy_d;
    logic         transfer;

    logic [NUM_BIAS-1:0][DATA_WIDTH-1:0] biasSet_q, biasSet_d;
    logic [NUM_BIAS-1:0][DATA_WIDTH-1:0] shadowWords;

    assign transfer = (state_q == LOAD) && in_valid_i;

    bias_shadow_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_BIAS   (NUM_BIAS)
    ) shadowBank (
        .clk      (clk),
        .clear_i  (rst),
        .wrEn_i   (transfer),
        .wrIdx_i  (wrIdx_q),
        .wrData_i (in_data_i),
        .rdData_o (shadowWords)
    );

    always_comb begin
        state_d   = state_q;
        wrIdx_d   = wrIdx_q;
        loaded_d  = loaded_q;
        biasSet_d = biasSet_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d  = LOAD;
                    wrIdx_d  = '0;
                    loaded_d = 1'b0;
                end
            end
            LOAD: begin
                // wrIdx wraps back to 0 on the last word, ready for the next load
                if (transfer) begin
                    wrIdx_d = wrIdx_q + 2'd1;
                    if (wrIdx_q == IDX_OUT) begin
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                biasSet_d = shadowWords;
                loaded_d  = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wrIdx_q   <= '0;
            loaded_q  <= 1'b0;
            busy_q    <= 1'b0;
            biasSet_q <= '0;
        end else begin
            state_q   <= state_d;
            wrIdx_q   <= wrIdx_d;
            loaded_q  <= loaded_d;
            busy_q    <= busy_d;
            biasSet_q <= biasSet_d;
        end
    end

    assign in_ready_o    = (state_q == LOAD);
    assign wr_idx_o      = wrIdx_q;
    assign loaded_o      = loaded_q;
    assign busy_o        = busy_q;
    assign bias_hid_o    = biasSet_q[IDX_HID];
    assign bias_hid_10_o = biasSet_q[IDX_HID_10];
    assign bias_hid_20_o = biasSet_q[IDX_HID_20];
    assign bias_out_o    = biasSet_q[IDX_OUT];

endmodule

// File: tb/tb_bias_loader.sv
// Self-checking bench for bias_loader: directed load scenarios followed by
// random traffic, every cycle compared against a transaction-level model.
module tb_bias_loader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] inData;
    logic       inValid;
    logic       inReady;
    logic [1:0] wrIdx;
    logic [7:0] biasHid, biasHid10, biasHid20, biasOut;
    logic       loaded;
    logic       busy;

    int totalChecks = 0;
    int badChecks   = 0;

    // Reference model: phase 0 idle, 1 collecting words, 2 committing
    int         phase;
    logic [7:0] collected[$];
    logic [7:0] committed[4];
    bit         modelLoaded;

    bias_loader dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .in_data_i     (inData),
        .in_valid_i    (inValid),
        .in_ready_o    (inReady),
        .wr_idx_o      (wrIdx),
        .bias_hid_o    (biasHid),
        .bias_hid_10_o (biasHid10),
        .bias_hid_20_o (biasHid20),
        .bias_out_o    (biasOut),
        .loaded_o      (loaded),
        .busy_o        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s at %0t: got=%0h want=%0h", tag, $time, observed, expected);
        end
    endtask

    // Advance the model by one clock edge using the inputs about to be sampled
    task automatic modelEdge();
        if (rst) begin
            phase       = 0;
            collected   = {};
            modelLoaded = 1'b0;
            for (int i = 0; i < 4; i++) committed[i] = 8'h00;
        end else if (phase == 0) begin
            if (start) begin
                phase       = 1;
                collected   = {};
                modelLoaded = 1'b0;
            end
        end else if (phase == 1) begin
            if (inValid) begin
                collected.push_back(inData);
                if (collected.size() == 4) phase = 2;
            end
        end else begin
            for (int i = 0; i < 4; i++) committed[i] = collected[i];
            modelLoaded = 1'b1;
            phase       = 0;
        end
    endtask

    task automatic checkAll();
        logic [1:0] expIdx;
        expIdx = (phase == 1) ? 2'(collected.size()) : 2'd0;
        checkOutput("bias_hid",    {24'd0, biasHid},   {24'd0, committed[0]});
        checkOutput("bias_hid_10", {24'd0, biasHid10}, {24'd0, committed[1]});
        checkOutput("bias_hid_20", {24'd0, biasHid20}, {24'd0, committed[2]});
        checkOutput("bias_out",    {24'd0, biasOut},   {24'd0, committed[3]});
        checkOutput("loaded",      {31'd0, loaded},    {31'd0, modelLoaded});
        checkOutput("busy",        {31'd0, busy},      {31'd0, phase != 0});
        checkOutput("in_ready",    {31'd0, inReady},   {31'd0, phase == 1});
        checkOutput("wr_idx",      {30'd0, wrIdx},     {30'd0, expIdx});
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic v,
                                 input logic [7:0] d);
        rst     = r;
        start   = s;
        inValid = v;
        inData  = d;
        modelEdge();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic loadWords(input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input logic [7:0] w3);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, w0);
        applyStimulus(1'b0, 1'b0, 1'b1, w1);
        applyStimulus(1'b0, 1'b0, 1'b1, w2);
        applyStimulus(1'b0, 1'b0, 1'b1, w3);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] stallWords[4];
        int         sent;
        int         beat;

        rst = 1'b1; start = 1'b0; inValid = 1'b0; inData = 8'h00;
        phase = 0; modelLoaded = 1'b0;
        for (int i = 0; i < 4; i++) committed[i] = 8'h00;

        // Reset, then idle with valid held high and no start
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A);

        // Back-to-back load
        loadWords(8'h11, 8'h22, 8'h33, 8'h44);

        // Stalled handshake: valid pattern 1,0,0 repeating
        stallWords[0] = 8'hA0; stallWords[1] = 8'hA1;
        stallWords[2] = 8'hA2; stallWords[3] = 8'hA3;
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        sent = 0;
        beat = 0;
        while (sent < 4) begin
            if (beat % 3 == 0) begin
                applyStimulus(1'b0, 1'b0, 1'b1, stallWords[sent]);
                sent++;
            end else begin
                applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF);
            end
            beat++;
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Reload over a committed set
        loadWords(8'h05, 8'h06, 8'h07, 8'h08);

        // Start pulses during LOAD and during COMMIT are ignored
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h31);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h32);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h33);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h34);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h99);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h77);

        // Reset mid-load, then a clean full load
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hDE);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hAD);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hBE);
        applyStimulus(1'b1, 1'b0, 1'b1, 8'hEF);
        loadWords(8'h01, 8'h02, 8'h03, 8'h04);

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 1) == 1),
                          8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
